// File: rtl/data_mem_pkg.sv
// data_mem_pkg: access-size and FSM state encodings shared by the data memory.
package data_mem_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane steering for stores and extract/extend for loads.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    misalign_o = size_i == SZ_RSVD || (size_i == SZ_HALF && addr_i[0]) ||
                 (size_i == SZ_WORD && addr_i != 2'b00);
    be_o = misalign_o ? 4'b0000 :
           size_i == SZ_BYTE ? 4'b0001 << addr_i :
           size_i == SZ_HALF ? 4'b0011 << {addr_i[1], 1'b0} : 4'b1111;
    // replicate store data so every enabled lane sees the right bits
    wword_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
              size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    byte_v = rword_i[{addr_i, 3'b000} +: 8];
    half_v = rword_i[{addr_i[1], 4'b0000} +: 16];
    rdata_o = size_i == SZ_BYTE ? {{24{signed_i & byte_v[7]}}, byte_v} :
              size_i == SZ_HALF ? {{16{signed_i & half_v[15]}}, half_v} : rword_i;
  end
endmodule

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressed data memory with sized loads/stores, misalign
// faults, request/ready handshake and a zero-fill sweep.
module data_memory_sized
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_in,
  input  logic                  we_in,
  input  logic [1:0]            size_in,
  input  logic                  signed_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [31:0]           data_in,
  input  logic                  clear_in,
  output logic                  ready_out,
  output logic                  busy_out,
  output logic                  rvalid_out,
  output logic [31:0]           data_out,
  output logic                  fault_out
);
  localparam int WW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WW;
  logic [31:0]   mem_q [DEPTH];
  state_t        state_q;
  logic [WW-1:0] cnt_q;
  logic [WW-1:0] idx;
  logic          busy_q, rvalid_q, fault_q, acc, misalign;
  logic [31:0]   data_q, data_d, rword, rdata, wword;
  logic [3:0]    be;
  always_comb begin
    idx       = addr_in[ADDR_WIDTH-1:2];
    ready_out = state_q == ST_IDLE;
    acc       = req_in && ready_out;
    rword     = mem_q[idx];
    data_d    = misalign ? 32'h0 : rdata;
  end
  mem_lane_align u_align (
    .size_i     (size_in),
    .addr_i     (addr_in[1:0]),
    .signed_i   (signed_in),
    .wdata_i    (data_in),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (rdata),
    .misalign_o (misalign)
  );
  // the array has no reset; only the sweep zeroes it
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (state_q == ST_CLEAR) mem_q[cnt_q] <= 32'h0;
      else if (acc && we_in)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      busy_q   <= CLEAR_ON_RESET;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      data_q   <= 32'h0;
    end else begin
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (acc) begin
          fault_q <= misalign;
          if (!we_in) begin
            rvalid_q <= 1'b1;
            data_q   <= data_d;
          end
        end
        if (clear_in) begin
          state_q <= ST_CLEAR;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end
  assign busy_out   = busy_q;
  assign rvalid_out = rvalid_q;
  assign data_out   = data_q;
  assign fault_out  = fault_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: vector table plus sweep/reset sequences, checked through a scoreboard queue.
module tb_data_memory_sized;
  logic        clk_in = 1'b0, rst_in = 1'b1, req_in = 1'b0, we_in = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic        signed_in = 1'b0, clear_in = 1'b0;
  logic [9:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  logic        ready_out, busy_out, rvalid_out, fault_out;
  logic [31:0] data_out;
  int n_vec = 0, n_err = 0, n;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [9:0]  a;
    logic [31:0] wd;
    logic        flt;
    logic [31:0] d;
  } vec_t;
  typedef struct {
    logic        rv;
    logic        flt;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];
  vec_t tbl[20];

  data_memory_sized #(.ADDR_WIDTH(10), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .we_in(we_in),
    .size_in(size_in), .signed_in(signed_in), .addr_in(addr_in), .data_in(data_in),
    .clear_in(clear_in), .ready_out(ready_out), .busy_out(busy_out),
    .rvalid_out(rvalid_out), .data_out(data_out), .fault_out(fault_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready_out && cnt < 2000) begin
      @(posedge clk_in); #1;
      cnt++;
    end
  endtask

  // drive one access, then check the result in the cycle after accept
  task automatic apply(input vec_t v, input logic clr);
    exp_t e;
    req_in = 1'b1; we_in = v.we; size_in = v.sz; signed_in = v.sg;
    addr_in = v.a; data_in = v.wd; clear_in = clr;
    exp_q.push_back('{rv: !v.we, flt: v.flt, d: v.d});
    @(posedge clk_in); #1;
    req_in = 1'b0; clear_in = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("rvalid@%h", v.a), {31'b0, rvalid_out}, {31'b0, e.rv});
    chk($sformatf("fault@%h", v.a), {31'b0, fault_out}, {31'b0, e.flt});
    if (e.rv) chk($sformatf("data@%h", v.a), data_out, e.d);
  endtask

  initial begin
    tbl = '{
      '{0, 2'd2, 0, 10'h3FC, 32'h0,        0, 32'h00000000},
      '{1, 2'd2, 0, 10'h010, 32'h11223344, 0, 32'h0},
      '{1, 2'd0, 0, 10'h011, 32'h000000AA, 0, 32'h0},
      '{1, 2'd1, 0, 10'h012, 32'h0000BEEF, 0, 32'h0},
      '{0, 2'd2, 0, 10'h010, 32'h0,        0, 32'hBEEFAA44},
      '{0, 2'd0, 1, 10'h011, 32'h0,        0, 32'hFFFFFFAA},
      '{0, 2'd0, 0, 10'h011, 32'h0,        0, 32'h000000AA},
      '{0, 2'd1, 1, 10'h012, 32'h0,        0, 32'hFFFFBEEF},
      '{0, 2'd1, 0, 10'h012, 32'h0,        0, 32'h0000BEEF},
      '{1, 2'd1, 0, 10'h021, 32'h00001234, 1, 32'h0},
      '{0, 2'd2, 0, 10'h022, 32'h0,        1, 32'h00000000},
      '{0, 2'd3, 0, 10'h020, 32'h0,        1, 32'h00000000},
      '{1, 2'd3, 0, 10'h024, 32'hFFFFFFFF, 1, 32'h0},
      '{0, 2'd2, 0, 10'h020, 32'h0,        0, 32'h00000000},
      '{0, 2'd2, 0, 10'h024, 32'h0,        0, 32'h00000000},
      '{1, 2'd0, 0, 10'h023, 32'hFFFFFF80, 0, 32'h0},
      '{0, 2'd0, 1, 10'h023, 32'h0,        0, 32'hFFFFFF80},
      '{0, 2'd2, 0, 10'h020, 32'h0,        0, 32'h80000000},
      '{0, 2'd1, 1, 10'h010, 32'h0,        0, 32'hFFFFAA44},
      '{0, 2'd2, 1, 10'h010, 32'h0,        0, 32'hBEEFAA44}
    };
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_busy", {31'b0, busy_out}, 32'd1);
    chk("reset_ready", {31'b0, ready_out}, 32'd0);
    chk("reset_rvalid", {31'b0, rvalid_out}, 32'd0);
    chk("reset_fault", {31'b0, fault_out}, 32'd0);
    chk("reset_data", data_out, 32'h0);
    rst_in = 1'b0;
    wait_ready(n);
    chk("sweep_cycles", n, 256);
    chk("idle_busy", {31'b0, busy_out}, 32'd0);
    for (int i = 0; i < 20; i++) apply(tbl[i], 1'b0);
    // clear together with a load: load sees pre-clear data
    apply('{0, 2'd2, 0, 10'h010, 32'h0, 0, 32'hBEEFAA44}, 1'b1);
    chk("clr_busy", {31'b0, busy_out}, 32'd1);
    chk("clr_ready", {31'b0, ready_out}, 32'd0);
    wait_ready(n);
    chk("clr_sweep_cycles", n, 256);
    apply('{0, 2'd2, 0, 10'h010, 32'h0, 0, 32'h00000000}, 1'b0);
    // reset 100 cycles into a sweep restarts it
    clear_in = 1'b1;
    @(posedge clk_in); #1;
    clear_in = 1'b0;
    chk("sweep2_busy", {31'b0, busy_out}, 32'd1);
    repeat (100) @(posedge clk_in);
    #1 rst_in = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy_out}, 32'd1);
    chk("midrst_ready", {31'b0, ready_out}, 32'd0);
    chk("midrst_data", data_out, 32'h0);
    #1 rst_in = 1'b0;
    // store held through the sweep must wait, not be lost or swept away
    req_in = 1'b1; we_in = 1'b1; size_in = 2'd2; signed_in = 1'b0;
    addr_in = 10'h3FC; data_in = 32'hCAFEF00D;
    wait_ready(n);
    chk("midrst_sweep_cycles", n, 256);
    @(posedge clk_in); #1;
    req_in = 1'b0;
    chk("held_store_fault", {31'b0, fault_out}, 32'd0);
    chk("held_store_rvalid", {31'b0, rvalid_out}, 32'd0);
    apply('{0, 2'd2, 0, 10'h3FC, 32'h0, 0, 32'hCAFEF00D}, 1'b0);
    @(posedge clk_in); #1;
    chk("rvalid_pulse", {31'b0, rvalid_out}, 32'd0);
    chk("data_hold", data_out, 32'hCAFEF00D);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the CPU's flat 32-bit word data memory.
- Supports ARM-style byte, halfword and word loads and stores, addressed by byte, with zero or sign extension on loads.
- Uses a request/ready handshake with a one-cycle registered read, reports misaligned accesses, and zero-fills itself with a clear sweep after reset or on command.
- Sits between the execute/memory stage and the writeback mux.

Parameters:
- ADDR_WIDTH, 10: byte-address width. Depth is 2**(ADDR_WIDTH-2) 32-bit words, so every address is in range.
- CLEAR_ON_RESET, 1: 1 = run the zero-fill sweep after reset; 0 = go straight to IDLE.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- req_in  input  1  access request; accepted when req_in && ready_out.
- we_in  input  1  1 = store, 0 = load; sampled on accept.
- size_in  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- signed_in  input  1  load only: 1 = sign-extend, 0 = zero-extend.
- addr_in  input  ADDR_WIDTH  byte address.
- data_in  input  32  store data, LSB-justified.
- clear_in  input  1  start a zero-fill sweep; honoured in IDLE only.
- ready_out  output  1  combinational; 1 iff state == IDLE.
- busy_out  output  1  registered; 1 while in CLEAR.
- rvalid_out  output  1  registered one-cycle pulse; load result valid.
- data_out  output  32  load result; holds until the next load completes.
- fault_out  output  1  registered one-cycle pulse; access was misaligned or reserved.

Behaviour:
- Reset (async):
  - Outputs: rvalid_out=0, fault_out=0, data_out=0.
  - State CLEAR with busy_out=1 and sweep counter=0 if CLEAR_ON_RESET=1; otherwise IDLE with busy_out=0.
  - The memory array itself is not reset; only the sweep clears it.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_in=1.
  - CLEAR writes zero to word[cnt] each cycle and increments cnt.
  - CLEAR -> IDLE in the cycle after cnt reaches DEPTH-1, i.e. the sweep takes exactly DEPTH cycles. busy_out deasserts with that transition.
- Reset asserted mid-sweep: restart from cnt=0, or go to IDLE if CLEAR_ON_RESET=0.
- clear_in while in CLEAR: ignored.
- clear_in and an accepted request in the same IDLE cycle:
  - The request completes fully first. A load returns pre-clear data, and a store is written before the sweep overwrites it.
  - CLEAR is entered on the same edge.
- Alignment: the fault condition is any of
  - size = 01 with addr[0] = 1;
  - size = 10 with addr[1:0] != 00;
  - size = 11.
- Faulted access:
  - No memory write.
  - fault_out pulses in the cycle after accept.
  - A faulted load also pulses rvalid_out, with data_out=0.
- Store, little-endian, word index addr[ADDR_WIDTH-1:2]:
  - Byte: data_in[7:0] into lane addr[1:0].
  - Halfword: data_in[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Unaddressed lanes are untouched.
  - The write takes effect on the accepting edge.
- Load:
  - Array read registered on the accept edge; lane extract and extension applied before the data_out register.
  - rvalid_out=1 and data_out valid in the cycle after accept.
  - Extension: zero-extend when signed_in=0; when signed_in=1, copy bit 7 (byte) or bit 15 (halfword) into the upper bits. Word loads ignore signed_in.
- Back-to-back: one access per cycle. A load of an address stored in the previous cycle returns the new data.
- No access is accepted during CLEAR. Requests wait because ready_out=0; they are not dropped.

Decomposition:
- Package data_mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - FSM state encodings ST_IDLE, ST_CLEAR.
- Sub-module mem_lane_align: combinational.
  - Inputs: size, addr[1:0], signed, store data, raw read word.
  - Outputs: 4-bit byte-enable, lane-shifted write word, extended load word, misalign flag.
- Top level holds the array, FSM, sweep counter and output registers.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy_out=1 and ready_out=0 for exactly 256 cycles (ADDR_WIDTH=10), then ready_out=1. A word load of addr 0x3FC returns 0x00000000.
- Word store 0x11223344 @0x10, byte store 0xAA @0x11, halfword store 0xBEEF @0x12, then word load @0x10 -> 0xBEEFAA44, with rvalid_out=1 the cycle after accept.
- From the previous memory state:
  - signed byte load @0x11 -> 0xFFFFFFAA;
  - unsigned byte load @0x11 -> 0x000000AA;
  - signed halfword load @0x12 -> 0xFFFFBEEF.
- Halfword store @0x21 and word load @0x22 -> fault_out pulse on each; memory unchanged; the load shows rvalid_out=1 with data_out=0. size=11 also faults.
- In IDLE, clear_in together with a load @0x10 -> load returns 0xBEEFAA44, busy_out rises the next cycle, and after the sweep a load @0x10 returns 0.
- rst_in pulsed at cycle 100 of a sweep -> counter restarts, and busy_out remains high for a further 256 cycles.
